// File: rtl/voice_scheduler.sv
// voice_scheduler: sample-rate scheduler for the tt6581 voice datapath.
// Divides clk_i down to an audio sample tick. On each tick it runs one frame:
// the shared voice datapath is started for each voice in turn, each voice's
// result is added into an accumulator, and the frame total is published.
//
// Ports:
//   clk_i, rst_ni   system clock, asynchronous active-low reset
//   enable_i        run enable; low holds the tick counter at 0
//   overrun_clr_i   single-cycle clear for overrun_o
//   voice_sel_o     voice currently serviced by the datapath
//   start_o         one-cycle start request to the datapath
//   done_i, voice_i datapath result handshake and data
//   sample_o        last published mix, held between frames
//   sample_valid_o  one-cycle pulse when sample_o updates
//   overrun_o       sticky: a tick arrived while a frame was running
module voice_scheduler #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned CLK_DIV    = 1000,
  parameter int unsigned VOICE_W    = 10,
  parameter int unsigned MIX_W      = VOICE_W + 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               overrun_clr_i,
  output logic [1:0]         voice_sel_o,
  output logic               start_o,
  input  logic               done_i,
  input  logic [VOICE_W-1:0] voice_i,
  output logic [MIX_W-1:0]   sample_o,
  output logic               sample_valid_o,
  output logic               overrun_o
);

  localparam int unsigned    CNT_W      = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [1:0]     LAST_VOICE = 2'(NUM_VOICES - 1);

  // Parameter legality checks at elaboration time.
  if (NUM_VOICES < 1 || NUM_VOICES > 4) begin : g_bad_num_voices
    $error("voice_scheduler: NUM_VOICES must be in 1..4");
  end
  if (CLK_DIV < 2 * NUM_VOICES + 2) begin : g_bad_clk_div
    $error("voice_scheduler: CLK_DIV must be >= 2*NUM_VOICES+2");
  end
  if (MIX_W < VOICE_W) begin : g_bad_mix_w
    $error("voice_scheduler: MIX_W must be >= VOICE_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [MIX_W-1:0] acc;
  logic             tick_c;
  logic [MIX_W-1:0] sum_c;

  assign tick_c = enable_i && (cnt == CNT_MAX);
  assign sum_c  = acc + MIX_W'(voice_i);

  // Sample-tick divider; held at 0 while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (!enable_i || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Frame sequencer; start_o and sample_valid_o are single-cycle pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= S_IDLE;
      acc            <= '0;
      voice_sel_o    <= 2'd0;
      start_o        <= 1'b0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      start_o        <= 1'b0;
      sample_valid_o <= 1'b0;

      // A tick during a frame is dropped but flagged; set beats clear.
      if (tick_c && state != S_IDLE) begin
        overrun_o <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_o <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (tick_c) begin
            state       <= S_ISSUE;
            acc         <= '0;
            voice_sel_o <= 2'd0;
            start_o     <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_i) begin
            acc <= sum_c;
            if (voice_sel_o < LAST_VOICE) begin
              voice_sel_o <= voice_sel_o + 2'd1;
              state       <= S_ISSUE;
              start_o     <= 1'b1;
            end else begin
              sample_o       <= sum_c;
              sample_valid_o <= 1'b1;
              state          <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: two instances (CLK_DIV=1000, L=1 and
// CLK_DIV=8, L=5). Expected start/sample events are queued when stimulus is
// issued; per-instance monitors pop and compare whenever the DUT pulses.
module tb_voice_scheduler;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b, clr_a, clr_b;
  logic [1:0] sel_a, sel_b;
  logic       start_a, start_b, done_a, done_b;
  logic [9:0] voice_a, voice_b;
  logic [11:0] sample_a, sample_b;
  logic       valid_a, valid_b, ovr_a, ovr_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int spur_req_a = 0;
  logic [9:0] vals_a [3];
  logic [9:0] vals_b [3];

  ev_t qsa[$], qva[$], qsb[$], qvb[$];

  voice_scheduler #(.NUM_VOICES(3), .CLK_DIV(1000), .VOICE_W(10), .MIX_W(12)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .overrun_clr_i(clr_a),
    .voice_sel_o(sel_a), .start_o(start_a), .done_i(done_a), .voice_i(voice_a),
    .sample_o(sample_a), .sample_valid_o(valid_a), .overrun_o(ovr_a)
  );

  voice_scheduler #(.NUM_VOICES(3), .CLK_DIV(8), .VOICE_W(10), .MIX_W(12)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .overrun_clr_i(clr_b),
    .voice_sel_o(sel_b), .start_o(start_b), .done_i(done_b), .voice_i(voice_b),
    .sample_o(sample_b), .sample_valid_o(valid_b), .overrun_o(ovr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: unexpected pulse at cycle %0d, expected none", name, cyc);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Queue the events of one frame ticking at cycle t with datapath latency lat.
  function automatic void exp_frame(input bit b, input int t, input int lat,
                                    input int nst, input int sum, input bit pub);
    ev_t e;
    for (int k = 0; k < nst; k++) begin
      e.cyc = t + 1 + k * (lat + 1);
      e.val = k;
      if (b) qsb.push_back(e); else qsa.push_back(e);
    end
    if (pub) begin
      e.cyc = t + 1 + 3 * (lat + 1);
      e.val = sum;
      if (b) qvb.push_back(e); else qva.push_back(e);
    end
  endfunction

  // Datapath model A: latency 1, plus on-request spurious done pulses.
  initial begin : resp_a
    int pend, cnt, psel, spur_ack;
    pend = 0; cnt = 0; psel = 0; spur_ack = 0;
    done_a = 1'b0; voice_a = '0;
    forever begin
      @(negedge clk);
      done_a = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend != 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            done_a = 1'b1; voice_a = vals_a[psel]; pend = 0;
          end
        end else if (spur_req_a != spur_ack) begin
          done_a = 1'b1; voice_a = 10'd500; spur_ack = spur_req_a;
        end
        if (start_a) begin
          pend = 1; cnt = 1; psel = int'(sel_a);
        end
      end
    end
  end

  // Datapath model B: latency 5.
  initial begin : resp_b
    int pend, cnt, psel;
    pend = 0; cnt = 0; psel = 0;
    done_b = 1'b0; voice_b = '0;
    forever begin
      @(negedge clk);
      done_b = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend != 0) begin
          cnt = cnt - 1;
          if (cnt == 0) begin
            done_b = 1'b1; voice_b = vals_b[psel]; pend = 0;
          end
        end
        if (start_b) begin
          pend = 1; cnt = 5; psel = int'(sel_b);
        end
      end
    end
  end

  initial begin : mon_a
    ev_t e;
    forever begin
      @(negedge clk);
      if (start_a) begin
        if (qsa.size() == 0) unexpected("start_a");
        else begin
          e = qsa.pop_front();
          check("start_a_cycle", cyc, e.cyc);
          check("start_a_sel", int'(sel_a), e.val);
        end
      end
      if (valid_a) begin
        if (qva.size() == 0) unexpected("valid_a");
        else begin
          e = qva.pop_front();
          check("valid_a_cycle", cyc, e.cyc);
          check("sample_a", int'(sample_a), e.val);
        end
      end
    end
  end

  initial begin : mon_b
    ev_t e;
    forever begin
      @(negedge clk);
      if (start_b) begin
        if (qsb.size() == 0) unexpected("start_b");
        else begin
          e = qsb.pop_front();
          check("start_b_cycle", cyc, e.cyc);
          check("start_b_sel", int'(sel_b), e.val);
        end
      end
      if (valid_b) begin
        if (qvb.size() == 0) unexpected("valid_b");
        else begin
          e = qvb.pop_front();
          check("valid_b_cycle", cyc, e.cyc);
          check("sample_b", int'(sample_b), e.val);
        end
      end
    end
  end

  initial begin : main
    int ta, tb, tc;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    vals_a[0] = 10'd100; vals_a[1] = 10'd200; vals_a[2] = 10'd300;
    vals_b[0] = 10'd5;   vals_b[1] = 10'd10;  vals_b[2] = 10'd1000;

    wait_cyc(3);
    check("rst_sel_a", int'(sel_a), 0);
    check("rst_start_a", int'(start_a), 0);
    check("rst_sample_a", int'(sample_a), 0);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_ovr_a", int'(ovr_a), 0);
    check("rst_ovr_b", int'(ovr_b), 0);
    wait_cyc(4);
    rst_n = 1'b1;

    // Overrun scenario on instance B while A sits disabled.
    wait_cyc(10);
    en_b = 1'b1;
    tb = 17;
    exp_frame(1'b1, tb, 5, 3, 1015, 1'b1);
    exp_frame(1'b1, tb + 24, 5, 3, 1015, 1'b1);
    wait_cyc(tb + 8);  check("ovr_b_before", int'(ovr_b), 0);
    wait_cyc(tb + 9);  check("ovr_b_set", int'(ovr_b), 1);
    wait_cyc(tb + 12); clr_b = 1'b1;
    wait_cyc(tb + 13); clr_b = 1'b0; check("ovr_b_clr", int'(ovr_b), 0);
    wait_cyc(tb + 17); check("ovr_b_reset2", int'(ovr_b), 1);
    wait_cyc(tb + 20); clr_b = 1'b1;
    wait_cyc(tb + 21); clr_b = 1'b0; check("ovr_b_clr2", int'(ovr_b), 0);
    wait_cyc(tb + 32); clr_b = 1'b1;
    wait_cyc(tb + 33); clr_b = 1'b0; check("ovr_b_set_wins", int'(ovr_b), 1);
    wait_cyc(tb + 45); en_b = 1'b0;

    // A stays idle with enable low.
    wait_cyc(3004);
    check("idle_sel_a", int'(sel_a), 0);
    check("idle_sample_a", int'(sample_a), 0);
    check("idle_ovr_a", int'(ovr_a), 0);

    // Basic frame, full scale, spurious done, then disable mid-frame.
    wait_cyc(3010);
    en_a = 1'b1;
    ta = 3010 + 999;
    exp_frame(1'b0, ta, 1, 3, 600, 1'b1);
    wait_cyc(ta + 20);
    vals_a[0] = 10'd1023; vals_a[1] = 10'd1023; vals_a[2] = 10'd1023;
    exp_frame(1'b0, ta + 1000, 1, 3, 3069, 1'b1);
    wait_cyc(ta + 1020);
    spur_req_a = spur_req_a + 1;
    exp_frame(1'b0, ta + 2000, 1, 3, 3069, 1'b1);
    wait_cyc(ta + 2020);
    vals_a[0] = 10'd1; vals_a[1] = 10'd2; vals_a[2] = 10'd3;
    exp_frame(1'b0, ta + 3000, 1, 3, 6, 1'b1);
    wait_cyc(ta + 3002);
    en_a = 1'b0;
    wait_cyc(ta + 5500);
    check("ovr_a_clean", int'(ovr_a), 0);
    check("sample_a_held", int'(sample_a), 6);

    // Reset in the middle of a frame.
    wait_cyc(ta + 5510);
    en_a = 1'b1;
    tc = ta + 5510 + 999;
    exp_frame(1'b0, tc, 1, 2, 0, 1'b0);
    wait_cyc(tc + 4);
    rst_n = 1'b0;
    en_a = 1'b0;
    #1;
    check("midrst_sample_a", int'(sample_a), 0);
    check("midrst_sel_a", int'(sel_a), 0);
    check("midrst_start_a", int'(start_a), 0);
    check("midrst_valid_a", int'(valid_a), 0);
    wait_cyc(tc + 10);
    rst_n = 1'b1;
    wait_cyc(tc + 40);
    check("post_sample_a", int'(sample_a), 0);
    check("left_qsa", qsa.size(), 0);
    check("left_qva", qva.size(), 0);
    check("left_qsb", qsb.size(), 0);
    check("left_qvb", qvb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
